// File: rtl/perceptron_unit.sv
// ---------------------------------------------------------------------------
// perceptron_unit
// Single-neuron binary perceptron with on-line training (perceptron rule,
// learning rate 1) and inference. Samples are accepted through a
// valid/ready handshake and walked through IDLE -> ACC -> EVAL -> DONE.
// ACC adds one weight per cycle, EVAL applies the step activation and any
// training update, and DONE presents the result for one cycle.
//
// Optional feature macro: PERCEPTRON_WLOAD_EN
//   Adds w_load / w_idx / w_data so that weights and bias can be preloaded
//   while the unit is idle. Without the macro the weights change only
//   through reset and training.
// ---------------------------------------------------------------------------
module perceptron_unit #(
   parameter int N_INPUTS   = 2,
   parameter int W_WIDTH    = 8,
   parameter int CONV_COUNT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef PERCEPTRON_WLOAD_EN
   input  logic                          w_load,
   input  logic [$clog2(N_INPUTS+1)-1:0] w_idx,
   input  logic [W_WIDTH-1:0]            w_data,
`endif
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_INPUTS-1:0]           x,
   input  logic                          target,
   input  logic                          train,
   output logic                          out_valid,
   output logic                          y,
   output logic                          err,
   output logic                          converged,
   output logic [N_INPUTS*W_WIDTH-1:0]   w_out,
   output logic [W_WIDTH-1:0]            b_out
);

   // Index counter wide enough to hold 0..N_INPUTS (N_INPUTS selects the bias
   // on the load port). The accumulator has one extra bit on top of the
   // worst-case sum of N_INPUTS weights plus the bias, so it never overflows.
   localparam int IDX_W    = $clog2(N_INPUTS + 1);
   localparam int ACC_W    = W_WIDTH + IDX_W + 1;
   localparam int STREAK_W = 8;

   localparam logic [STREAK_W-1:0] CONV_LIMIT = STREAK_W'(CONV_COUNT);
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_INPUTS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_EVAL = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
   localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

   logic [1:0]                  state;
   logic [N_INPUTS-1:0]         x_lat;
   logic [N_INPUTS-1:0]         x_shift;
   logic                        target_lat;
   logic                        train_lat;
   logic [IDX_W-1:0]            index;
   logic signed [ACC_W-1:0]     acc;

   logic signed [W_WIDTH-1:0]   weights [N_INPUTS];
   logic signed [W_WIDTH-1:0]   bias;

   logic                        y_r;
   logic                        err_r;
   logic                        converged_r;
   logic [STREAK_W-1:0]         streak;

   logic                        accept;
   logic                        last_index;
   logic signed [W_WIDTH-1:0]   sel_weight;
   logic signed [ACC_W-1:0]     sel_ext;
   logic signed [ACC_W-1:0]     bias_ext;
   logic signed [ACC_W-1:0]     acc_add;
   logic signed [ACC_W-1:0]     sum;
   logic                        y_eval;
   logic                        err_eval;
   logic [STREAK_W-1:0]         streak_next;
   logic                        load_fire;

   // One saturating +/-1 step; weights and bias clamp at the two's-complement
   // limits instead of wrapping around.
   function automatic logic signed [W_WIDTH-1:0] step_sat(
      input logic signed [W_WIDTH-1:0] value,
      input logic                      up
   );
      logic signed [W_WIDTH-1:0] result;
      result = value;
      if (up) begin
         if (value != W_MAX)
            result = value + W_WIDTH'(1);
      end else begin
         if (value != W_MIN)
            result = value - W_WIDTH'(1);
      end
      return result;
   endfunction

`ifdef PERCEPTRON_WLOAD_EN
   // A preload takes priority over a new sample, so the unit stops accepting
   // while w_load is high; loads are only honoured in IDLE with no sample.
   assign in_ready  = (state == ST_IDLE) && !w_load;
   assign load_fire = (state == ST_IDLE) && w_load && !in_valid;
`else
   assign in_ready  = (state == ST_IDLE);
   assign load_fire = 1'b0;
`endif

   assign accept     = in_valid && in_ready;
   assign last_index = (index == LAST_IDX);

   // Pick the weight paired with the current accumulation index. A compare
   // loop is used so the index width never has to match the array size.
   always_comb begin
      sel_weight = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (index == IDX_W'(i))
            sel_weight = weights[i];
      end
   end

   assign sel_ext  = {{(ACC_W-W_WIDTH){sel_weight[W_WIDTH-1]}}, sel_weight};
   assign bias_ext = {{(ACC_W-W_WIDTH){bias[W_WIDTH-1]}}, bias};
   assign acc_add  = acc + (x_shift[0] ? sel_ext : '0);
   assign sum      = acc + bias_ext;

   // Step activation fires only for a strictly positive sum.
   assign y_eval   = !sum[ACC_W-1] && (sum != '0);
   assign err_eval = train_lat && (y_eval != target_lat);

   // Streak of consecutive correct training samples, saturating at the limit.
   always_comb begin
      streak_next = streak;
      if (err_eval)
         streak_next = '0;
      else if (streak < CONV_LIMIT)
         streak_next = streak + STREAK_W'(1);
   end

   // Sequencer: handshake, per-input accumulation and the fixed-length
   // EVAL/DONE tail. Reset drops any in-flight sample immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         x_lat      <= '0;
         x_shift    <= '0;
         target_lat <= 1'b0;
         train_lat  <= 1'b0;
         index      <= '0;
         acc        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  x_lat      <= x;
                  x_shift    <= x;
                  target_lat <= target;
                  train_lat  <= train;
                  index      <= '0;
                  acc        <= '0;
                  state      <= ST_ACC;
               end
            end
            ST_ACC: begin
               acc     <= acc_add;
               x_shift <= x_shift >> 1;
               index   <= index + IDX_W'(1);
               if (last_index)
                  state <= ST_EVAL;
            end
            ST_EVAL: begin
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Weight and bias registers: perceptron-rule update on a training error in
   // EVAL, or a direct write from the preload port while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_INPUTS; i++)
            weights[i] <= '0;
         bias <= '0;
      end else if (state == ST_EVAL) begin
         if (err_eval) begin
            for (int i = 0; i < N_INPUTS; i++) begin
               if (x_lat[i])
                  weights[i] <= step_sat(weights[i], target_lat);
            end
            bias <= step_sat(bias, target_lat);
         end
`ifdef PERCEPTRON_WLOAD_EN
      end else if (load_fire) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            if (w_idx == IDX_W'(i))
               weights[i] <= w_data;
         end
         if (w_idx == IDX_W'(N_INPUTS))
            bias <= w_data;
`endif
      end
   end

   // Result and convergence tracking. y/err are captured in EVAL and held
   // until the next EVAL; inference samples leave the streak untouched, and a
   // valid preload restarts convergence from scratch.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r         <= 1'b0;
         err_r       <= 1'b0;
         streak      <= '0;
         converged_r <= 1'b0;
      end else if (state == ST_EVAL) begin
         y_r   <= y_eval;
         err_r <= err_eval;
         if (train_lat) begin
            streak      <= streak_next;
            converged_r <= (streak_next == CONV_LIMIT);
         end
`ifdef PERCEPTRON_WLOAD_EN
      end else if (load_fire && (w_idx <= IDX_W'(N_INPUTS))) begin
         streak      <= '0;
         converged_r <= 1'b0;
`endif
      end
   end

   // Flatten the weight array onto the observation bus.
   always_comb begin
      w_out = '0;
      for (int i = 0; i < N_INPUTS; i++)
         w_out[i*W_WIDTH +: W_WIDTH] = weights[i];
   end

   assign b_out     = bias;
   assign out_valid = (state == ST_DONE);
   assign y         = y_r;
   assign err       = err_r;
   assign converged = converged_r;

`ifndef PERCEPTRON_WLOAD_EN
   // load_fire is tied low in this build; fold it into a harmless term so the
   // signal stays referenced.
   logic load_unused;
   assign load_unused = load_fire;
`endif

endmodule

// File: tb/tb_perceptron_unit.sv
// ---------------------------------------------------------------------------
// tb_perceptron_unit
// Self-checking bench for perceptron_unit. A behavioural model (integer
// weights, plain sum and threshold, clamp on update) predicts every result.
// When PERCEPTRON_WLOAD_EN is defined the DUT is built with W_WIDTH=4 and
// the preload port is exercised as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perceptron_unit;

   localparam int N    = 2;
`ifdef PERCEPTRON_WLOAD_EN
   localparam int WW   = 4;
`else
   localparam int WW   = 8;
`endif
   localparam int CONV = 4;
   localparam int IW   = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    x;
   logic            target;
   logic            train;
   logic            out_valid;
   logic            y;
   logic            err;
   logic            converged;
   logic [N*WW-1:0] w_out;
   logic [WW-1:0]   b_out;
`ifdef PERCEPTRON_WLOAD_EN
   logic            w_load;
   logic [IW-1:0]   w_idx;
   logic [WW-1:0]   w_data;
`endif

   int errors = 0;
   int checks = 0;

   int mw [N];
   int mb;
   int mstreak;

   perceptron_unit #(
      .N_INPUTS  (N),
      .W_WIDTH   (WW),
      .CONV_COUNT(CONV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef PERCEPTRON_WLOAD_EN
      .w_load   (w_load),
      .w_idx    (w_idx),
      .w_data   (w_data),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .target   (target),
      .train    (train),
      .out_valid(out_valid),
      .y        (y),
      .err      (err),
      .converged(converged),
      .w_out    (w_out),
      .b_out    (b_out)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int clamp(input int v);
      int lo;
      int hi;
      lo = -(1 << (WW - 1));
      hi = (1 << (WW - 1)) - 1;
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mw[i] = 0;
      mb      = 0;
      mstreak = 0;
   endtask

   task automatic model_step(input logic [N-1:0] sx, input logic st, input logic str,
                             output logic ey, output logic eerr, output logic econv);
      int sum;
      int delta;
      sum = mb;
      for (int i = 0; i < N; i++) if (sx[i]) sum += mw[i];
      ey    = (sum > 0);
      eerr  = str && (ey != st);
      delta = st ? 1 : -1;
      if (str) begin
         if (eerr) begin
            for (int i = 0; i < N; i++) if (sx[i]) mw[i] = clamp(mw[i] + delta);
            mb      = clamp(mb + delta);
            mstreak = 0;
         end else if (mstreak < CONV) begin
            mstreak++;
         end
      end
      econv = (mstreak == CONV);
   endtask

   function automatic logic [N*WW-1:0] model_wvec();
      logic [N*WW-1:0] v;
      for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'(mw[i]);
      return v;
   endfunction

   function automatic logic [WW-1:0] model_bias();
      return WW'(mb);
   endfunction

   // ---------------- stimulus driver ----------------
   // Offers one sample, waits (bounded) for acceptance and then for the result
   // strobe. Returns at the falling edge inside the out_valid cycle. lat counts
   // cycles from the accepting edge; busy_ok drops if in_ready was seen high
   // while the sample was in flight.
   task automatic run_sample(input logic [N-1:0] sx, input logic st, input logic str,
                             output logic oy, output logic oerr, output logic oconv,
                             output int lat, output logic busy_ok, output logic to);
      int n;
      to      = 1'b0;
      busy_ok = 1'b1;
      lat     = 0;
      oy      = 1'b0;
      oerr    = 1'b0;
      oconv   = 1'b0;
      @(negedge clk);
      x        = sx;
      target   = st;
      train    = str;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         to       = 1'b1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 50) begin
         if (in_ready) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!out_valid) to = 1'b1;
      if (in_ready) busy_ok = 1'b0;
      oy    = y;
      oerr  = err;
      oconv = converged;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL reset_y: got %b expected 0", y); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL reset_converged: got %b expected 0", converged); end
      checks++; if (w_out !== '0) begin errors++; $display("[TB] FAIL reset_w_out: got %h expected 0", w_out); end
      checks++; if (b_out !== '0) begin errors++; $display("[TB] FAIL reset_b_out: got %h expected 0", b_out); end
   endtask

   task automatic test_latency();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      int   lat;
      model_step('1, 1'b0, 1'b0, ey, eerr, econv);
      run_sample('1, 1'b0, 1'b0, oy, oerr, oconv, lat, busy_ok, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL latency_timeout: got timeout expected result"); end
      checks++; if (lat != N + 2) begin errors++; $display("[TB] FAIL latency_cycles: got %0d expected %0d", lat, N + 2); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("[TB] FAIL latency_in_ready_busy: got in_ready high in flight expected low"); end
      checks++; if (oy !== ey) begin errors++; $display("[TB] FAIL latency_y: got %b expected %b", oy, ey); end
      checks++; if (oerr !== 1'b0) begin errors++; $display("[TB] FAIL latency_err: got %b expected 0", oerr); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_one_cycle_strobe: got %b expected 0", out_valid); end
   endtask

   task automatic test_and_training();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      logic [N-1:0]    sx;
      logic            st;
      logic [N*WW-1:0] ew;
      int   lat;
      int   first_conv;
      int   late_errs;
      first_conv = 0;
      late_errs  = 0;
      for (int s = 1; s <= 24; s++) begin
         sx = N'((s - 1) % 4);
         st = (((s - 1) % 4) == 3);
         model_step(sx, st, 1'b1, ey, eerr, econv);
         run_sample(sx, st, 1'b1, oy, oerr, oconv, lat, busy_ok, to);
         checks++; if (to) begin errors++; $display("[TB] FAIL and_timeout[%0d]: got timeout expected result", s); end
         checks++; if (oy !== ey) begin errors++; $display("[TB] FAIL and_y[%0d]: got %b expected %b", s, oy, ey); end
         checks++; if (oerr !== eerr) begin errors++; $display("[TB] FAIL and_err[%0d]: got %b expected %b", s, oerr, eerr); end
         checks++; if (oconv !== econv) begin errors++; $display("[TB] FAIL and_conv[%0d]: got %b expected %b", s, oconv, econv); end
         checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL and_w_out[%0d]: got %h expected %h", s, w_out, model_wvec()); end
         checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL and_b_out[%0d]: got %h expected %h", s, b_out, model_bias()); end
         if (oconv && first_conv == 0) first_conv = s;
         if (s >= 19 && oerr) late_errs++;
      end
      ew = '0;
      ew[WW +: WW] = WW'(2);
      ew[0  +: WW] = WW'(1);
      checks++; if (w_out !== ew) begin errors++; $display("[TB] FAIL and_final_weights: got %h expected %h", w_out, ew); end
      checks++; if (b_out !== WW'(-2)) begin errors++; $display("[TB] FAIL and_final_bias: got %h expected %h", b_out, WW'(-2)); end
      checks++; if (first_conv != 22) begin errors++; $display("[TB] FAIL and_first_converged: got sample %0d expected 22", first_conv); end
      checks++; if (late_errs != 0) begin errors++; $display("[TB] FAIL and_late_errors: got %0d expected 0", late_errs); end
   endtask

   task automatic test_inference();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      logic [N-1:0] pats [3];
      logic         want [3];
      int   lat;
      pats[0] = 2'b11; want[0] = 1'b1;
      pats[1] = 2'b10; want[1] = 1'b0;
      pats[2] = 2'b00; want[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         model_step(pats[k], 1'b0, 1'b0, ey, eerr, econv);
         run_sample(pats[k], 1'b0, 1'b0, oy, oerr, oconv, lat, busy_ok, to);
         checks++; if (to) begin errors++; $display("[TB] FAIL infer_timeout[%0d]: got timeout expected result", k); end
         checks++; if (oy !== want[k]) begin errors++; $display("[TB] FAIL infer_y[%0d]: got %b expected %b", k, oy, want[k]); end
         checks++; if (oy !== ey) begin errors++; $display("[TB] FAIL infer_model_y[%0d]: got %b expected %b", k, oy, ey); end
         checks++; if (oerr !== 1'b0) begin errors++; $display("[TB] FAIL infer_err[%0d]: got %b expected 0", k, oerr); end
         checks++; if (oconv !== econv) begin errors++; $display("[TB] FAIL infer_conv[%0d]: got %b expected %b", k, oconv, econv); end
         checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL infer_w_out[%0d]: got %h expected %h", k, w_out, model_wvec()); end
         checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL infer_b_out[%0d]: got %h expected %h", k, b_out, model_bias()); end
      end
   endtask

   task automatic test_back_to_back();
      logic ey, eerr, econv;
      int   pulses [$];
      model_step('1, 1'b0, 1'b0, ey, eerr, econv);
      @(negedge clk);
      x        = '1;
      target   = 1'b0;
      train    = 1'b0;
      in_valid = 1'b1;
      for (int c = 1; c <= 4 * (N + 3); c++) begin
         @(negedge clk);
         if (out_valid) begin
            pulses.push_back(c);
            checks++; if (y !== ey) begin errors++; $display("[TB] FAIL b2b_y[%0d]: got %b expected %b", c, y, ey); end
         end
      end
      in_valid = 1'b0;
      checks++; if (pulses.size() < 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected at least 3", pulses.size()); end
      for (int k = 1; k < pulses.size(); k++) begin
         checks++;
         if (pulses[k] - pulses[k-1] != N + 3) begin
            errors++;
            $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", k, pulses[k] - pulses[k-1], N + 3);
         end
      end
      repeat (N + 4) @(negedge clk);
   endtask

   task automatic test_streak_reset();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      logic [N*WW-1:0] ew;
      int   lat;
      model_step('1, 1'b0, 1'b1, ey, eerr, econv);
      run_sample('1, 1'b0, 1'b1, oy, oerr, oconv, lat, busy_ok, to);
      ew = '0;
      ew[WW +: WW] = WW'(1);
      ew[0  +: WW] = WW'(0);
      checks++; if (to) begin errors++; $display("[TB] FAIL streak_timeout: got timeout expected result"); end
      checks++; if (oerr !== 1'b1) begin errors++; $display("[TB] FAIL streak_err: got %b expected 1", oerr); end
      checks++; if (oconv !== 1'b0) begin errors++; $display("[TB] FAIL streak_conv: got %b expected 0", oconv); end
      checks++; if (w_out !== ew) begin errors++; $display("[TB] FAIL streak_weights: got %h expected %h", w_out, ew); end
      checks++; if (b_out !== WW'(-3)) begin errors++; $display("[TB] FAIL streak_bias: got %h expected %h", b_out, WW'(-3)); end
      checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL streak_model_w: got %h expected %h", w_out, model_wvec()); end
   endtask

   task automatic test_random();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      logic [N-1:0] sx;
      logic         st, str;
      int   lat;
      for (int s = 0; s < 40; s++) begin
         sx  = N'($urandom_range(0, (1 << N) - 1));
         st  = 1'($urandom_range(0, 1));
         str = ($urandom_range(0, 3) != 0);
         model_step(sx, st, str, ey, eerr, econv);
         run_sample(sx, st, str, oy, oerr, oconv, lat, busy_ok, to);
         checks++; if (to) begin errors++; $display("[TB] FAIL rand_timeout[%0d]: got timeout expected result", s); end
         checks++; if (oy !== ey) begin errors++; $display("[TB] FAIL rand_y[%0d]: got %b expected %b", s, oy, ey); end
         checks++; if (oerr !== eerr) begin errors++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", s, oerr, eerr); end
         checks++; if (oconv !== econv) begin errors++; $display("[TB] FAIL rand_conv[%0d]: got %b expected %b", s, oconv, econv); end
         checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL rand_w_out[%0d]: got %h expected %h", s, w_out, model_wvec()); end
         checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL rand_b_out[%0d]: got %h expected %h", s, b_out, model_bias()); end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      @(negedge clk);
      x        = '1;
      target   = 1'b1;
      train    = 1'b1;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
      checks++; if (y !== 1'b0) begin errors++; $display("[TB] FAIL midrst_y: got %b expected 0", y); end
      checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL midrst_converged: got %b expected 0", converged); end
      checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL midrst_w_out: got %h expected %h", w_out, model_wvec()); end
      checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL midrst_b_out: got %h expected %h", b_out, model_bias()); end
      pulses = 0;
      repeat (N + 5) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL midrst_discarded: got %0d strobes expected 0", pulses); end
      checks++; if (w_out !== '0) begin errors++; $display("[TB] FAIL midrst_no_update: got %h expected 0", w_out); end
   endtask

`ifdef PERCEPTRON_WLOAD_EN
   task automatic do_load(input logic [IW-1:0] idx, input logic [WW-1:0] data);
      @(negedge clk);
      w_load   = 1'b1;
      w_idx    = idx;
      w_data   = data;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_in_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      w_load = 1'b0;
      if (int'(idx) < N) begin
         mw[idx] = int'($signed(data));
         mstreak = 0;
      end else if (int'(idx) == N) begin
         mb      = int'($signed(data));
         mstreak = 0;
      end
   endtask

   task automatic test_weight_load();
      logic ey, eerr, econv, oy, oerr, oconv, busy_ok, to;
      logic [N-1:0] tx [4];
      logic         tt [4];
      logic [N*WW-1:0] ew;
      int   lat;
      // Spec scenario: all registers at the positive limit, then an error.
      do_load(IW'(N), WW'(7));
      do_load(IW'(0), WW'(7));
      do_load(IW'(1), WW'(7));
      checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL load_w_out: got %h expected %h", w_out, model_wvec()); end
      checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL load_b_out: got %h expected %h", b_out, model_bias()); end
      model_step('1, 1'b0, 1'b1, ey, eerr, econv);
      run_sample('1, 1'b0, 1'b1, oy, oerr, oconv, lat, busy_ok, to);
      ew = '0;
      ew[WW +: WW] = WW'(6);
      ew[0  +: WW] = WW'(6);
      checks++; if (oerr !== 1'b1) begin errors++; $display("[TB] FAIL load_train_err: got %b expected 1", oerr); end
      checks++; if (w_out !== ew) begin errors++; $display("[TB] FAIL load_train_w: got %h expected %h", w_out, ew); end
      checks++; if (b_out !== WW'(6)) begin errors++; $display("[TB] FAIL load_train_b: got %h expected 6", b_out); end
      // Out-of-range index is ignored.
      do_load(IW'(N + 1), WW'(5));
      checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL load_bad_idx_w: got %h expected %h", w_out, model_wvec()); end
      checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL load_bad_idx_b: got %h expected %h", b_out, model_bias()); end
      // Bias at the negative limit with a correct sample: no wrap.
      do_load(IW'(N), WW'(-8));
      model_step('0, 1'b0, 1'b1, ey, eerr, econv);
      run_sample('0, 1'b0, 1'b1, oy, oerr, oconv, lat, busy_ok, to);
      checks++; if (oy !== 1'b0) begin errors++; $display("[TB] FAIL load_neg_y: got %b expected 0", oy); end
      checks++; if (oerr !== 1'b0) begin errors++; $display("[TB] FAIL load_neg_err: got %b expected 0", oerr); end
      checks++; if (b_out !== WW'(-8)) begin errors++; $display("[TB] FAIL load_neg_bias: got %h expected 8", b_out); end
      // Saturation in both directions on training updates.
      tx[0] = '1; tt[0] = 1'b0;
      tx[1] = '1; tt[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            do_load(IW'(0), WW'(-8)); do_load(IW'(1), WW'(7)); do_load(IW'(N), WW'(7));
         end else begin
            do_load(IW'(0), WW'(7)); do_load(IW'(1), WW'(-8)); do_load(IW'(N), WW'(-8));
         end
         model_step(tx[k], tt[k], 1'b1, ey, eerr, econv);
         run_sample(tx[k], tt[k], 1'b1, oy, oerr, oconv, lat, busy_ok, to);
         checks++; if (oerr !== eerr) begin errors++; $display("[TB] FAIL sat_err[%0d]: got %b expected %b", k, oerr, eerr); end
         checks++; if (oconv !== econv) begin errors++; $display("[TB] FAIL sat_conv[%0d]: got %b expected %b", k, oconv, econv); end
         checks++; if (w_out !== model_wvec()) begin errors++; $display("[TB] FAIL sat_w[%0d]: got %h expected %h", k, w_out, model_wvec()); end
         checks++; if (b_out !== model_bias()) begin errors++; $display("[TB] FAIL sat_b[%0d]: got %h expected %h", k, b_out, model_bias()); end
      end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      x        = '0;
      target   = 1'b0;
      train    = 1'b0;
`ifdef PERCEPTRON_WLOAD_EN
      w_load   = 1'b0;
      w_idx    = '0;
      w_data   = '0;
`endif
      model_reset();
      $display("[TB] starting perceptron_unit bench, N=%0d W=%0d", N, WW);
      test_reset();
      test_latency();
      test_and_training();
      test_inference();
      test_back_to_back();
      test_streak_reset();
      test_random();
      test_reset_mid();
`ifdef PERCEPTRON_WLOAD_EN
      test_weight_load();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/perceptron_unit.md
Name: perceptron_unit

Overview:
- Single-neuron binary perceptron with N_INPUTS binary inputs, signed weights and bias, and a step activation.
- Supports on-line training (perceptron rule, learning rate 1) and inference.
- Generalises the fixed 2-input AND gate: it learns AND, OR, NAND or any other linearly separable N-input gate from labelled samples.
- Sits in the lab datapath between a sample source (testbench or pattern ROM) and a result sink.

Parameters:
- N_INPUTS, 2, number of binary inputs (1..16).
- W_WIDTH, 8, width of each signed two's-complement weight and of the bias.
- CONV_COUNT, 4, consecutive correct training samples required to assert converged (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  sample present.
- in_ready  output  1  unit can accept a sample.
- x  input  N_INPUTS  binary input vector; x[i] pairs with weight i.
- target  input  1  expected output; used only when train=1.
- train  input  1  1 = train on this sample, 0 = inference only.
- out_valid  output  1  one-cycle result strobe.
- y  output  1  activation result for the last sample.
- err  output  1  y != target (training samples only; 0 for inference).
- converged  output  1  CONV_COUNT consecutive correct training samples seen.
- w_out  output  N_INPUTS*W_WIDTH  weights, weight i at bits [i*W_WIDTH +: W_WIDTH].
- b_out  output  W_WIDTH  bias.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All weights 0, bias 0.
  - y=0, err=0, out_valid=0, converged=0, streak counter 0.
  - FSM in IDLE, in_ready=1.
- Reset mid-operation: any state returns to IDLE on the next edge. Any in-flight sample is discarded and its update is never applied.
- FSM: IDLE -> ACC -> EVAL -> DONE -> IDLE.
  - IDLE: in_ready=1. A transfer occurs on in_valid&&in_ready. On transfer, latch x, target and train, clear the accumulator, set index=0, go to ACC.
  - ACC: lasts N_INPUTS cycles. Each cycle, if x[index]=1, add weight[index] to the accumulator; then index++. After index N_INPUTS-1, go to EVAL.
  - EVAL: lasts 1 cycle. sum = acc + bias; y = (sum > 0), strictly positive.
    - If train=1 and y!=target: for every i with x[i]=1, weight[i] += (target ? +1 : -1); bias += (target ? +1 : -1).
    - Weights and bias saturate at -2^(W_WIDTH-1) and 2^(W_WIDTH-1)-1; they never wrap.
  - DONE: lasts 1 cycle. out_valid=1; y and err are valid and held until the next EVAL.
- Accumulator width: W_WIDTH + clog2(N_INPUTS+1) + 1 bits, signed. It cannot overflow.
- Latency and throughput:
  - in_ready=0 from ACC through DONE.
  - out_valid asserts exactly N_INPUTS+2 cycles after the accepting edge.
  - Maximum throughput is one sample per N_INPUTS+3 cycles.
  - There is no output backpressure; the sink must take out_valid when it is presented.
- Streak counter and converged:
  - Training sample with err=0: streak increments, saturating at CONV_COUNT.
  - Training sample with err=1: streak clears to 0.
  - converged = (streak == CONV_COUNT). It updates in EVAL, so it is visible together with out_valid.
  - Inference samples leave weights, bias, streak and converged unchanged.
- w_out and b_out always show the current registers. An update becomes visible in the cycle after EVAL.

Optional Feature:
- Macro: PERCEPTRON_WLOAD_EN.
- When defined, three ports are added:
  - w_load (input 1).
  - w_idx (input clog2(N_INPUTS+1)).
  - w_data (input W_WIDTH).
- Load rules:
  - A load happens only in IDLE, when w_load=1 and in_valid=0.
  - The load writes w_data into weight[w_idx]. w_idx==N_INPUTS targets the bias. Larger indices are ignored.
  - Every load clears the streak and converged.
  - w_load outside IDLE is ignored.
  - w_load has priority over in_valid: in_ready=0 while w_load=1.
- Without the macro: the ports are absent, and weights change only through reset and training.

Test Plan:
- Reset: assert rst for 2 cycles mid-ACC -> next cycle in_ready=1, out_valid=0, y=0, converged=0, w_out=0, b_out=0.
- Latency (N_INPUTS=2): accept x=2'b11 with train=0 at edge T -> out_valid high only in cycle T+4, y=0, err=0; in_ready low during T+1..T+4.
- AND training (defaults, weights 0): repeat patterns 00/01/10/11 with targets 0/0/0/1, train=1 -> final w[1]=2, w[0]=1, bias=-2; converged first high with out_valid of sample 22; err=0 on every sample from sample 19 on.
- Inference after AND training: x=11 -> y=1; x=10 -> y=0; x=00 -> y=0. Weights and converged unchanged.
- Streak reset: after convergence, train x=11 with target=0 -> err=1, converged=0, w[1]=1, w[0]=0, bias=-3.
- PERCEPTRON_WLOAD_EN with W_WIDTH=4: load bias=7, w[0]=7, w[1]=7, then train x=11 with target=0 -> err=1, w[1]=6, w[0]=6, bias=6. Load bias=-8, then train x=00 with target=0 -> y=0, err=0, bias remains -8 (no wrap).
